// File: rtl/fpoperations.sv
// fpoperations: shared FPU definitions.
//   - fop_* opcodes used by the issue/decode side of the FP unit.
//   - Exception flag bit positions within ret[5:0] and fpcsr[5:0].
//   - Completion port encoding (u1/u3/u5) and the round-robin successor helper.
package fpoperations;

    // FP opcodes
    localparam logic [4:0] fop_add  = 5'd0;
    localparam logic [4:0] fop_sub  = 5'd1;
    localparam logic [4:0] fop_mul  = 5'd2;
    localparam logic [4:0] fop_div  = 5'd3;
    localparam logic [4:0] fop_sqrt = 5'd4;
    localparam logic [4:0] fop_cmp  = 5'd5;
    localparam logic [4:0] fop_cvt  = 5'd6;

    // Exception flag bit indices (ret[5:0], fpcsr[5:0] trap enables)
    localparam int FEX_INV = 0;
    localparam int FEX_DZ  = 1;
    localparam int FEX_OVF = 2;
    localparam int FEX_UNF = 3;
    localparam int FEX_INX = 4;
    localparam int FEX_DEN = 5;
    localparam int FEX_W   = 6;

    // Completion stream widths
    localparam int RET_W = 14;
    localparam int FUS_W = 6;
    localparam int NPORT = 3;

    // Completion port encoding
    localparam logic [1:0] PORT_U1 = 2'd0;
    localparam logic [1:0] PORT_U3 = 2'd1;
    localparam logic [1:0] PORT_U5 = 2'd2;

    // Round-robin successor over {u1, u3, u5}
    function automatic logic [1:0] port_next(input logic [1:0] p);
        return (p == PORT_U5) ? PORT_U1 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fpu_ret_fifo.sv
// fpu_ret_fifo: per-port completion FIFO with a combinational head.
//   clk, rst  : clock, asynchronous active-high reset (drops all entries)
//   push, din : enqueue request and data ({fus, ret})
//   pop       : dequeue request (ignored when empty)
//   full/empty: occupancy status
//   count     : number of entries, log2(DEPTH)+1 bits
//   head      : oldest entry, valid while !empty
module fpu_ret_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               head
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_ok, pop_ok;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

`ifdef swapedge
    always_ff @(negedge clk or posedge rst) begin
`else
    always_ff @(posedge clk or posedge rst) begin
`endif
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    // Storage is not reset; pointers/count define what is valid.
`ifdef swapedge
    always_ff @(negedge clk) begin
`else
    always_ff @(posedge clk) begin
`endif
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/fpu_ret_collect.sv
// fpu_ret_collect: merges the u1/u3/u5 FPU completion streams into one
// round-robin stream for retire, with per-port FIFOs, sticky exception
// flags and trap detection.
//   clk, rst            : clock, asynchronous active-high reset
//   fpcsr               : [5:0] trap enables
//   uN_ret, uN_ret_en   : completion code / valid per port (no upstream stall)
//   FUS0..FUS2          : compare flags for u1/u3/u5, sampled with ret_en
//   flag_clr            : clear sticky flags (same-cycle new flags survive)
//   out_valid/out_ready : output handshake
//   out_port/ret/fus    : head entry of the granted port
//   out_trap            : head exception flags hit an enabled trap
//   port_afull          : per-port almost-full, bit 0 = u1
//   sticky_flags        : accumulated exception flags
//   ovf_err             : sticky, an enqueue was dropped on a full FIFO
module fpu_ret_collect
    import fpoperations::*;
#(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       fpcsr,
    input  logic [RET_W-1:0]  u1_ret,
    input  logic [RET_W-1:0]  u3_ret,
    input  logic [RET_W-1:0]  u5_ret,
    input  logic              u1_ret_en,
    input  logic              u3_ret_en,
    input  logic              u5_ret_en,
    input  logic [FUS_W-1:0]  FUS0,
    input  logic [FUS_W-1:0]  FUS1,
    input  logic [FUS_W-1:0]  FUS2,
    input  logic              flag_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_port,
    output logic [RET_W-1:0]  out_ret,
    output logic [FUS_W-1:0]  out_fus,
    output logic              out_trap,
    output logic [NPORT-1:0]  port_afull,
    output logic [FEX_W-1:0]  sticky_flags,
    output logic              ovf_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = FUS_W + RET_W;

    logic [RET_W-1:0] ret_arr [NPORT];
    logic [FUS_W-1:0] fus_arr [NPORT];
    logic [NPORT-1:0] ret_en;
    logic [NPORT-1:0] full, empty, pop;
    logic [CNT_W-1:0] count [NPORT];
    logic [ENT_W-1:0] head  [NPORT];

    logic [1:0]       rr_reg;
    logic             lock_reg;
    logic [1:0]       lock_port_reg;
    logic [FEX_W-1:0] sticky_reg, sticky_next;
    logic             ovf_reg;

    logic [1:0]       grant;
    logic             found;
    int               scan_idx;
    logic             head_empty;
    logic [ENT_W-1:0] head_sel;
    logic             handshake;
    logic [FEX_W-1:0] new_flags;
    logic [25:0]      unused_fpcsr;

    assign ret_arr[0] = u1_ret;
    assign ret_arr[1] = u3_ret;
    assign ret_arr[2] = u5_ret;
    assign fus_arr[0] = FUS0;
    assign fus_arr[1] = FUS1;
    assign fus_arr[2] = FUS2;
    assign ret_en     = {u5_ret_en, u3_ret_en, u1_ret_en};

    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            fpu_ret_fifo #(
                .DEPTH (DEPTH),
                .W     (ENT_W)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (ret_en[gi]),
                .din   ({fus_arr[gi], ret_arr[gi]}),
                .pop   (pop[gi]),
                .full  (full[gi]),
                .empty (empty[gi]),
                .count (count[gi]),
                .head  (head[gi])
            );
            assign pop[gi]        = handshake & (grant == 2'(gi));
            assign port_afull[gi] = (count[gi] >= CNT_W'(AFULL_LVL));
        end
    endgenerate

    // Grant: a stalled head keeps its grant so the presented entry stays
    // stable; otherwise scan for the first non-empty port starting at rr.
    always_comb begin
        grant    = rr_reg;
        found    = 1'b0;
        scan_idx = 0;
        if (lock_reg) begin
            grant = lock_port_reg;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                scan_idx = (int'(rr_reg) + k) % NPORT;
                if (!found && !empty[scan_idx]) begin
                    grant = 2'(scan_idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_empty = 1'b1;
        head_sel   = '0;
        case (grant)
            PORT_U1: begin head_empty = empty[0]; head_sel = head[0]; end
            PORT_U3: begin head_empty = empty[1]; head_sel = head[1]; end
            PORT_U5: begin head_empty = empty[2]; head_sel = head[2]; end
            default: begin head_empty = 1'b1;     head_sel = '0;      end
        endcase
    end

    assign out_valid = ~head_empty;
    assign handshake = out_valid & out_ready;
    assign out_port  = out_valid ? grant : 2'd0;
    assign out_ret   = out_valid ? head_sel[RET_W-1:0] : '0;
    assign out_fus   = out_valid ? head_sel[ENT_W-1:RET_W] : '0;
    assign out_trap  = out_valid & (|(out_ret[FEX_W-1:0] & fpcsr[FEX_W-1:0]));

    assign unused_fpcsr = fpcsr[31:6];

    // Flags are gathered from every completing op, including one dropped
    // on overflow: the exception itself still happened.
    always_comb begin
        new_flags = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (ret_en[k]) new_flags = new_flags | ret_arr[k][FEX_W-1:0];
        end
        sticky_next = (flag_clr ? '0 : sticky_reg) | new_flags;
    end

`ifdef swapedge
    always_ff @(negedge clk or posedge rst) begin
`else
    always_ff @(posedge clk or posedge rst) begin
`endif
        if (rst) begin
            rr_reg        <= PORT_U1;
            lock_reg      <= 1'b0;
            lock_port_reg <= PORT_U1;
            sticky_reg    <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            if (handshake) begin
                rr_reg   <= port_next(grant);
                lock_reg <= 1'b0;
            end else if (out_valid) begin
                lock_reg      <= 1'b1;
                lock_port_reg <= grant;
            end
            sticky_reg <= sticky_next;
            if (|(ret_en & full & ~pop)) ovf_reg <= 1'b1;
        end
    end

    assign sticky_flags = sticky_reg;
    assign ovf_err      = ovf_reg;

endmodule

// File: tb/tb_fpu_ret_collect.sv
module tb_fpu_ret_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fpcsr;
    logic [13:0] u1_ret, u3_ret, u5_ret;
    logic        u1_ret_en, u3_ret_en, u5_ret_en;
    logic [5:0]  FUS0, FUS1, FUS2;
    logic        flag_clr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_port;
    logic [13:0] out_ret;
    logic [5:0]  out_fus;
    logic        out_trap;
    logic [2:0]  port_afull;
    logic [5:0]  sticky_flags;
    logic        ovf_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fpu_ret_collect #(.DEPTH(8), .AFULL_LVL(4)) dut (
        .clk(clk), .rst(rst), .fpcsr(fpcsr),
        .u1_ret(u1_ret), .u3_ret(u3_ret), .u5_ret(u5_ret),
        .u1_ret_en(u1_ret_en), .u3_ret_en(u3_ret_en), .u5_ret_en(u5_ret_en),
        .FUS0(FUS0), .FUS1(FUS1), .FUS2(FUS2),
        .flag_clr(flag_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
        .out_ret(out_ret), .out_fus(out_fus), .out_trap(out_trap),
        .port_afull(port_afull), .sticky_flags(sticky_flags), .ovf_err(ovf_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u1_ret_en = 0; u3_ret_en = 0; u5_ret_en = 0;
        u1_ret = '0; u3_ret = '0; u5_ret = '0;
        FUS0 = '0; FUS1 = '0; FUS2 = '0;
        flag_clr = 0;
    endtask

    // Called at posedge+1; pulses rst between edges.
    task automatic do_reset();
        idle_inputs();
        out_ready = 0; fpcsr = '0;
        rst = 1; #3; rst = 0; #1;
    endtask

    task automatic test_reset();
        rst = 1; fpcsr = '0; out_ready = 0; idle_inputs();
        #1;
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end n_cmp++;
        if (out_ret !== 14'h0) begin n_mis++; $display("FAIL reset_ret got=%0h exp=0", out_ret); end n_cmp++;
        if (port_afull !== 3'b000) begin n_mis++; $display("FAIL reset_afull got=%0h exp=0", port_afull); end n_cmp++;
        if (sticky_flags !== 6'h0) begin n_mis++; $display("FAIL reset_sticky got=%0h exp=0", sticky_flags); end n_cmp++;
        if (ovf_err !== 1'b0) begin n_mis++; $display("FAIL reset_ovf got=%0h exp=0", ovf_err); end n_cmp++;
        step(); step();
        rst = 0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_single_port();
        do_reset();
        out_ready = 1;
        u1_ret_en = 1; u1_ret = 14'h0011; FUS0 = 6'h2A;
        #1;
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL single_early_valid got=%0h exp=0", out_valid); end n_cmp++;
        step();
        idle_inputs();
        if (out_valid !== 1'b1) begin n_mis++; $display("FAIL single_valid got=%0h exp=1", out_valid); end n_cmp++;
        if (out_port !== 2'd0) begin n_mis++; $display("FAIL single_port got=%0h exp=0", out_port); end n_cmp++;
        if (out_ret !== 14'h0011) begin n_mis++; $display("FAIL single_ret got=%0h exp=11", out_ret); end n_cmp++;
        if (out_fus !== 6'h2A) begin n_mis++; $display("FAIL single_fus got=%0h exp=2a", out_fus); end n_cmp++;
        if (sticky_flags !== 6'h11) begin n_mis++; $display("FAIL single_sticky got=%0h exp=11", sticky_flags); end n_cmp++;
        step();
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL single_drained got=%0h exp=0", out_valid); end n_cmp++;
        $display("test_single_port done");
    endtask

    task automatic test_three_ports();
        do_reset();
        out_ready = 1;
        u1_ret_en = 1; u1_ret = 14'h0040; FUS0 = 6'h01;
        u3_ret_en = 1; u3_ret = 14'h0080; FUS1 = 6'h02;
        u5_ret_en = 1; u5_ret = 14'h00C0; FUS2 = 6'h03;
        step();
        idle_inputs();
        if (out_port !== 2'd0 || out_ret !== 14'h0040) begin n_mis++; $display("FAIL three_first got=%0h/%0h exp=0/40", out_port, out_ret); end n_cmp++;
        step();
        if (out_port !== 2'd1 || out_ret !== 14'h0080) begin n_mis++; $display("FAIL three_second got=%0h/%0h exp=1/80", out_port, out_ret); end n_cmp++;
        step();
        if (out_port !== 2'd2 || out_fus !== 6'h03) begin n_mis++; $display("FAIL three_third got=%0h/%0h exp=2/3", out_port, out_fus); end n_cmp++;
        step();
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL three_empty got=%0h exp=0", out_valid); end n_cmp++;
        // rr should be back at u1: u1 wins over u5 when both arrive together
        u1_ret_en = 1; u1_ret = 14'h0140;
        u5_ret_en = 1; u5_ret = 14'h0100;
        step();
        idle_inputs();
        if (out_port !== 2'd0) begin n_mis++; $display("FAIL three_rr_wrap got=%0h exp=0", out_port); end n_cmp++;
        step();
        if (out_port !== 2'd2 || out_ret !== 14'h0100) begin n_mis++; $display("FAIL three_rr_next got=%0h/%0h exp=2/100", out_port, out_ret); end n_cmp++;
        step();
        $display("test_three_ports done");
    endtask

    task automatic test_lock();
        do_reset();
        out_ready = 0;
        u3_ret_en = 1; u3_ret = 14'h0100; FUS1 = 6'h05;
        step();
        idle_inputs();
        if (out_valid !== 1'b1 || out_port !== 2'd1) begin n_mis++; $display("FAIL lock_first got=%0h/%0h exp=1/1", out_valid, out_port); end n_cmp++;
        // u1 (higher priority at rr=u1) and u5 arrive while u3 is stalled
        u1_ret_en = 1; u1_ret = 14'h0200;
        u5_ret_en = 1; u5_ret = 14'h0300;
        step();
        idle_inputs();
        if (out_port !== 2'd1 || out_ret !== 14'h0100 || out_fus !== 6'h05) begin n_mis++; $display("FAIL lock_hold got=%0h/%0h exp=1/100", out_port, out_ret); end n_cmp++;
        step();
        if (out_port !== 2'd1) begin n_mis++; $display("FAIL lock_hold2 got=%0h exp=1", out_port); end n_cmp++;
        out_ready = 1;
        step();
        // rr moved past u3 -> u5 before u1
        if (out_port !== 2'd2 || out_ret !== 14'h0300) begin n_mis++; $display("FAIL lock_after_u5 got=%0h/%0h exp=2/300", out_port, out_ret); end n_cmp++;
        step();
        if (out_port !== 2'd0 || out_ret !== 14'h0200) begin n_mis++; $display("FAIL lock_after_u1 got=%0h/%0h exp=0/200", out_port, out_ret); end n_cmp++;
        step();
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL lock_empty got=%0h exp=0", out_valid); end n_cmp++;
        $display("test_lock done");
    endtask

    task automatic test_fill();
        logic [13:0] exp_q [8];
        do_reset();
        out_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            u5_ret_en = 1; u5_ret = 14'(i << 6);
            step();
            if (i == 3) begin
                if (port_afull !== 3'b000) begin n_mis++; $display("FAIL fill_afull3 got=%0h exp=0", port_afull); end n_cmp++;
            end
            if (i == 4) begin
                if (port_afull !== 3'b100) begin n_mis++; $display("FAIL fill_afull4 got=%0h exp=4", port_afull); end n_cmp++;
            end
        end
        if (ovf_err !== 1'b0) begin n_mis++; $display("FAIL fill_ovf_pre got=%0h exp=0", ovf_err); end n_cmp++;
        u5_ret = 14'(9 << 6);
        step();
        idle_inputs();
        if (ovf_err !== 1'b1) begin n_mis++; $display("FAIL fill_ovf got=%0h exp=1", ovf_err); end n_cmp++;
        if (out_port !== 2'd2 || out_ret !== 14'h0040) begin n_mis++; $display("FAIL fill_head got=%0h/%0h exp=2/40", out_port, out_ret); end n_cmp++;
        // full FIFO, same-cycle pop: 10th entry is kept
        u5_ret_en = 1; u5_ret = 14'(10 << 6);
        out_ready = 1;
        step();
        idle_inputs();
        if (port_afull !== 3'b100) begin n_mis++; $display("FAIL fill_afull_keep got=%0h exp=4", port_afull); end n_cmp++;
        for (int j = 0; j < 7; j++) exp_q[j] = 14'((j + 2) << 6);
        exp_q[7] = 14'(10 << 6);
        for (int j = 0; j < 8; j++) begin
            $display("drain %0d port=%0d ret=%h", j, out_port, out_ret);
            if (out_valid !== 1'b1 || out_ret !== exp_q[j]) begin n_mis++; $display("FAIL fill_drain%0d got=%0h/%0h exp=1/%0h", j, out_valid, out_ret, exp_q[j]); end n_cmp++;
            step();
        end
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL fill_empty got=%0h exp=0", out_valid); end n_cmp++;
        if (ovf_err !== 1'b1) begin n_mis++; $display("FAIL fill_ovf_sticky got=%0h exp=1", ovf_err); end n_cmp++;
        $display("test_fill done");
    endtask

    task automatic test_trap_flags();
        do_reset();
        out_ready = 0;
        fpcsr = 32'h0000_0004;
        u1_ret_en = 1; u1_ret = 14'h0004;
        step();
        idle_inputs();
        if (out_trap !== 1'b1) begin n_mis++; $display("FAIL trap_on got=%0h exp=1", out_trap); end n_cmp++;
        if (sticky_flags !== 6'h04) begin n_mis++; $display("FAIL trap_sticky got=%0h exp=4", sticky_flags); end n_cmp++;
        fpcsr = 32'h0000_0001;
        #1;
        if (out_trap !== 1'b0) begin n_mis++; $display("FAIL trap_off got=%0h exp=0", out_trap); end n_cmp++;
        flag_clr = 1; u3_ret_en = 1; u3_ret = 14'h0010;
        step();
        idle_inputs();
        if (sticky_flags !== 6'h10) begin n_mis++; $display("FAIL clr_new got=%0h exp=10", sticky_flags); end n_cmp++;
        flag_clr = 1;
        step();
        idle_inputs();
        if (sticky_flags !== 6'h00) begin n_mis++; $display("FAIL clr_only got=%0h exp=0", sticky_flags); end n_cmp++;
        $display("test_trap_flags done");
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            u1_ret_en = 1; u1_ret = 14'(i); FUS0 = 6'(i);
            step();
        end
        idle_inputs();
        if (out_valid !== 1'b1 || port_afull !== 3'b001 || sticky_flags !== 6'h07) begin n_mis++; $display("FAIL midop_pre got=%0h/%0h/%0h exp=1/1/7", out_valid, port_afull, sticky_flags); end n_cmp++;
        #2;
        rst = 1;
        #1;
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL midop_valid got=%0h exp=0", out_valid); end n_cmp++;
        if (out_port !== 2'd0 || out_ret !== 14'h0 || out_fus !== 6'h0 || out_trap !== 1'b0) begin n_mis++; $display("FAIL midop_out got=%0h/%0h/%0h/%0h exp=0", out_port, out_ret, out_fus, out_trap); end n_cmp++;
        if (port_afull !== 3'b000 || sticky_flags !== 6'h0 || ovf_err !== 1'b0) begin n_mis++; $display("FAIL midop_state got=%0h/%0h/%0h exp=0", port_afull, sticky_flags, ovf_err); end n_cmp++;
        #2;
        rst = 0;
        out_ready = 1;
        u3_ret_en = 1; u3_ret = 14'h0123; FUS1 = 6'h15;
        step();
        idle_inputs();
        if (out_valid !== 1'b1 || out_port !== 2'd1 || out_ret !== 14'h0123 || out_fus !== 6'h15) begin n_mis++; $display("FAIL midop_post got=%0h/%0h/%0h/%0h exp=1/1/123/15", out_valid, out_port, out_ret, out_fus); end n_cmp++;
        step();
        if (out_valid !== 1'b0) begin n_mis++; $display("FAIL midop_post_empty got=%0h exp=0", out_valid); end n_cmp++;
        $display("test_reset_midop done");
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_three_ports();
        test_lock();
        test_fill();
        test_trap_flags();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fpu_ret_collect.md
# fpu_ret_collect

Collects the per-port completion stream produced by the dual-half FP unit (ret codes and compare flags for ports u1/u3/u5) and presents it to retire as one in-order-per-port, round-robin-merged stream. It has a valid/ready handshake, accumulates sticky IEEE exception flags for fpcsr, and flags trap-enabled exceptions. It sits between the FPU's ret/FUS outputs and the retire/fpcsr logic, and gives the scheduler per-port backpressure.

## Interface
- DEPTH, 8: per-port FIFO entries (power of two, >=4).
- AFULL_LVL, 4: count at or above which the port's almost-full is raised. Covers the 4-stage op-to-ret latency.
- clk  in  1  clock. Active edge is posedge, or negedge when `swapedge` is defined.
- rst  in  1  reset, asynchronous, active-high.
- fpcsr  in  32  bits [5:0] are the trap enables, one per exception flag.
- u1_ret, u3_ret, u5_ret  in  14 each  completion code. Bits [5:0] are the exception flags: invalid, div0, overflow, underflow, inexact, denormal.
- u1_ret_en, u3_ret_en, u5_ret_en  in  1 each  completion valid. No stall is possible upstream.
- FUS0, FUS1, FUS2  in  6 each  compare flags for u1/u3/u5. Sampled in the same cycle as the matching ret_en.
- flag_clr  in  1  clear the sticky flags.
- out_valid  out  1  head entry available.
- out_ready  in  1  retire accepts.
- out_port  out  2  source port: 0=u1, 1=u3, 2=u5.
- out_ret  out  14  ret of the head entry.
- out_fus  out  6  FUS of the head entry.
- out_trap  out  1  (out_ret[5:0] & fpcsr[5:0]) != 0, evaluated at drain.
- port_afull  out  3  per-port almost-full, bit 0 = u1.
- sticky_flags  out  6  accumulated exception flags.
- ovf_err  out  1  sticky: an enqueue hit a full FIFO.

## Operation
- Enqueue: ret_en=1 writes {ret, FUS} into that port's FIFO at the active edge. All three ports may enqueue in the same cycle.
- Full FIFO, no dequeue of that port in the same cycle: the entry is dropped and ovf_err is set.
- Full FIFO with a same-cycle dequeue of that port: the entry is accepted and count stays DEPTH.
- Sticky flags are updated at enqueue, not drain: sticky <= (flag_clr ? 0 : sticky) | OR of ret[5:0] over all enqueuing ports. New flags survive a simultaneous clear.
- ovf_err is cleared only by rst.
- Arbitration:
  - Round-robin pointer rr over {u1, u3, u5}; reset value u1.
  - The grant is the first non-empty port starting at rr.
  - On handshake (out_valid & out_ready), rr moves to the port after the granted one.
  - While out_valid & !out_ready, the grant is locked. out_port/out_ret/out_fus/out_trap hold stable even if a higher-priority port fills.
- out_valid = the granted port's FIFO is non-empty. Outputs come combinationally from the FIFO head, with no bubble between successive drains.
- Per-port order is strict FIFO. Cross-port order is arbitration order only.
- port_afull[i] = count_i >= AFULL_LVL. The scheduler must stop issuing to port i while it is set.

## Timing
- Reset values:
  - out_valid=0, out_trap=0, out_port=0, out_ret=0, out_fus=0, port_afull=0, sticky_flags=0, ovf_err=0.
  - All counts and pointers 0, rr=u1, lock cleared.
- Reset mid-operation drops all queued entries immediately, asynchronously.
- Latency: ret_en in cycle N gives out_valid in N+1 at the earliest (empty FIFO, port granted).
- Throughput: one drain per cycle total, up to three enqueues per cycle.
- Counts use log2(DEPTH)+1 bits. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- port_afull and sticky_flags are registered and reflect the state after the edge. out_trap is combinational from the head entry and the current fpcsr.

## Structure
- Sub-module fpu_ret_fifo (parameter DEPTH; width 20 = {fus, ret}):
  - push, pop, full, empty, count, head.
  - Push on full is accepted only when pop is active in the same cycle.
- Exception flag bit indices (FEX_INV..FEX_DEN) and the port encoding constants go in fpoperations.sv alongside the fop_* opcodes. No new package.
- Top level holds the arbiter (rr, lock), the sticky flag register, ovf_err, and the output mux.

## Test plan
- Single port: u1 ret_en with ret=0x0011, FUS=0x2A, out_ready=1 -> next cycle out_valid=1, out_port=0, out_ret=0x0011, out_fus=0x2A; sticky_flags=0x11.
- All three ports enqueue one entry each in one cycle, out_ready=1 -> drains u1, u3, u5 on consecutive cycles; rr returns to u1.
- Backpressure lock: u3 queued, out_ready=0, then u1 enqueues -> out_port stays 1 until handshake; then u5-or-u1 order follows rr.
- Fill u5 with 8 entries, out_ready=0 -> port_afull[2]=1 after the 4th. A 9th entry sets ovf_err=1 and is dropped. A 9th entry in a cycle where u5 is popped is kept.
- fpcsr[2]=1, entry ret[2]=1 at head -> out_trap=1. flag_clr together with a new ret[4]=1 -> sticky_flags=0x10.
- Assert rst with 5 entries queued -> out_valid=0 immediately and all outputs at reset values; the first post-reset enqueue drains normally.
